// File: rtl/serial_adder_if.sv
// rtl/serial_adder_if.sv - request/result bundle for the bit-serial add/subtract unit
interface serial_adder_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic             sub;
   logic             c_in;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] s;
   logic             c_out;
   logic             ovf;

   // requester side: issues operands, watches the handshake and results
   modport master (
      output start, sub, c_in, a, b,
      input  busy, done, s, c_out, ovf
   );

   // adder side: takes operands, returns handshake and results
   modport slave (
      input  start, sub, c_in, a, b,
      output busy, done, s, c_out, ovf
   );
endinterface

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial add/subtract unit, one full-adder cell, LSB first
module serial_adder #(
   parameter int WIDTH = 8
) (
   input  logic          clk,
   input  logic          rst,
   serial_adder_if.slave bus
);
   localparam int            CW   = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] a_sr;
   logic [WIDTH-1:0] b_sr;
   logic [WIDTH-1:0] res_sr;
   logic [WIDTH-1:0] s_q;
   logic [CW-1:0]    cnt;
   logic             carry;
   logic             busy_q;
   logic             done_q;
   logic             c_out_q;
   logic             ovf_q;
   logic             sum;
   logic             cout;

   // the single full-adder cell working on the current LSBs and the carry FF
   always_comb begin
      sum  = a_sr[0] ^ b_sr[0] ^ carry;
      cout = (a_sr[0] & b_sr[0]) | (a_sr[0] & carry) | (b_sr[0] & carry);
   end

   // control FSM plus datapath; every output comes straight from a register
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         a_sr    <= '0;
         b_sr    <= '0;
         res_sr  <= '0;
         s_q     <= '0;
         cnt     <= '0;
         carry   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         c_out_q <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         case (state)
            // DONE accepts a new start exactly like IDLE, giving back-to-back issue
            IDLE, DONE: begin
               done_q <= 1'b0;
               if (bus.start) begin
                  a_sr   <= bus.a;
                  // subtraction is a + ~b + 1: invert B here, force carry-in to 1
                  b_sr   <= bus.b ^ {WIDTH{bus.sub}};
                  carry  <= bus.sub ? 1'b1 : bus.c_in;
                  res_sr <= '0;
                  cnt    <= '0;
                  busy_q <= 1'b1;
                  state  <= RUN;
               end else begin
                  state  <= IDLE;
               end
            end
            RUN: begin
               a_sr   <= a_sr >> 1;
               b_sr   <= b_sr >> 1;
               res_sr <= {sum, res_sr[WIDTH-1:1]};
               carry  <= cout;
               if (cnt == LAST) begin
                  // carry still holds the carry into the MSB on this last bit
                  s_q     <= {sum, res_sr[WIDTH-1:1]};
                  c_out_q <= cout;
                  ovf_q   <= carry ^ cout;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state   <= DONE;
               end else begin
                  cnt     <= cnt + CW'(1);
               end
            end
            default: begin
               busy_q <= 1'b0;
               done_q <= 1'b0;
               state  <= IDLE;
            end
         endcase
      end
   end

   assign bus.busy  = busy_q;
   assign bus.done  = done_q;
   assign bus.s     = s_q;
   assign bus.c_out = c_out_q;
   assign bus.ovf   = ovf_q;
endmodule

// File: doc/serial_adder.md
# serial_adder

Parametrised bit-serial add/subtract unit built around a single full-adder cell and a carry flip-flop. It generalises the combinational half-adder cell: WIDTH-bit operands, carry-in, subtract mode, signed-overflow detection and a start/busy/done handshake. It processes one bit per clock, LSB first, and trades latency for area in the arithmetic section of the MSI component library.

## Interface
Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..64

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- start  input  1  request; sampled only when busy=0
- sub  input  1  0 = a+b+c_in, 1 = a-b (a + ~b + 1); sampled with start
- c_in  input  1  carry-in for add mode; ignored when sub=1; sampled with start
- a  input  WIDTH  operand A; sampled with start
- b  input  WIDTH  operand B; sampled with start
- busy  output  1  high while an operation is in progress
- done  output  1  one-cycle pulse when s/c_out/ovf become valid
- s  output  WIDTH  result, registered
- c_out  output  1  carry out of MSB (sub mode: 1 = no borrow)
- ovf  output  1  signed overflow: carry into MSB XOR carry out of MSB

## Operation
- State machine: IDLE, RUN, DONE.
- IDLE: busy=0, done=0. On start=1, capture a into A shift register, b XOR {WIDTH{sub}} into B shift register, carry FF = sub ? 1 : c_in, bit counter = 0, go to RUN.
- RUN: busy=1. Each cycle, the full-adder cell computes sum = A[0]^B[0]^carry and cout = majority(A[0],B[0],carry). It shifts sum into the MSB of the result shift register, shifts A and B right by one, carry <= cout, and counter increments. On the bit where counter = WIDTH-1, record carry-into-MSB (the carry FF value before the update). Then load s from the completed result register, c_out = cout, ovf = carry-into-MSB ^ cout, and go to DONE.
- DONE: busy=0, done=1 for exactly one cycle. start=1 here is accepted as in IDLE and goes directly to RUN (back-to-back). Otherwise go to IDLE.
- start while busy=1 is ignored. Input changes during RUN have no effect.
- s, c_out and ovf hold their value from the last completed operation until the next completion. They never show partial results.
- Counter width is clog2(WIDTH). It never wraps within an operation and is cleared on each accepted start.

## Timing
- Reset (rst=1 at a clock edge) forces: state IDLE, busy=0, done=0, s=0, c_out=0, ovf=0, counter=0, internal registers 0. rst takes priority over start.
- Reset during RUN aborts the operation. No done pulse is produced, and s/c_out/ovf read 0 afterwards.
- start is sampled at edge E. busy=1 from after E through edge E+WIDTH. After edge E+WIDTH, done=1 and outputs are valid, so latency is WIDTH+1 cycles from the sampling edge to the done cycle.
- Throughput with back-to-back start in the DONE cycle: one result per WIDTH+1 cycles.
- All outputs are driven from registers. There is no combinational path from inputs to outputs.

## Test plan
- WIDTH=8, add mode. Case 1: a=8'h3C, b=8'h5A, c_in=0 gives s=8'h96, c_out=0, ovf=1. Case 2: a=8'hFF, b=8'h01, c_in=0 gives s=8'h00, c_out=1, ovf=0. Case 3: a=8'h7F, b=8'h00, c_in=1 gives s=8'h80, c_out=0, ovf=1. In all cases done pulses once, exactly 9 cycles after the start edge.
- WIDTH=8, sub mode, c_in forced to 1 by stimulus to prove it is ignored. Case 1: a=8'h05, b=8'h07 gives s=8'hFE, c_out=0, ovf=0. Case 2: a=8'h80, b=8'h01 gives s=8'h7F, c_out=1, ovf=1.
- Handshake, with start held high continuously. Operations complete every 9 cycles. A start pulse mid-RUN is ignored, and operand changes mid-RUN do not alter the result. s is unchanged between done pulses.
- Reset mid-operation: assert rst on the 4th RUN cycle. The next cycle shows busy=0, done=0, s=0, c_out=0, ovf=0, and no done pulse follows. A new start then completes normally.
- Parameter sweep at WIDTH=2 and WIDTH=16:
  - Run 1000 random operands and modes against a reference model (a + (sub ? ~b : b) + (sub ? 1 : c_in)) and check s, c_out and ovf.
  - Check the latency is WIDTH+1 cycles.
  - Include corners: all-zeros, all-ones, MSB-only.
